// File: rtl/ours_vld_rdy_rr_arb_mux.sv
// Round-robin N:1 valid/ready arbiter-mux with a single registered output slot.
// The grant rotates past the last accepted requester; the output slot holds its payload until the consumer takes it.
module ours_vld_rdy_rr_arb_mux #(
  parameter int N_INPUT    = 2,
  parameter int DATA_WIDTH = 64,
  localparam int ID_W      = (N_INPUT > 1) ? $clog2(N_INPUT) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_INPUT-1:0]              in_vld,
  input  logic [N_INPUT*DATA_WIDTH-1:0]   in_data,
  output logic [N_INPUT-1:0]              in_rdy,
  output logic                            out_vld,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [ID_W-1:0]                 out_id,
  input  logic                            out_rdy
);

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic [ID_W-1:0]       last_id_q, last_id_d;

  logic                    slot_free;
  logic                    grant;
  logic                    found;
  int                      idx;
  logic [ID_W-1:0]         win_id;
  logic [DATA_WIDTH-1:0]   win_data;
  logic [N_INPUT-1:0]      vld_sh;
  logic [N_INPUT*DATA_WIDTH-1:0] data_sh;

  // Search from the requester after the last winner, wrapping to index 0.
  always_comb begin
    found    = 1'b0;
    idx      = 0;
    win_id   = '0;
    win_data = '0;
    vld_sh   = '0;
    data_sh  = '0;
    for (int k = 1; k <= N_INPUT; k++) begin
      idx    = (int'(last_id_q) + k) % N_INPUT;
      vld_sh = in_vld >> idx;
      if (!found && vld_sh[0]) begin
        found    = 1'b1;
        win_id   = ID_W'(idx);
        data_sh  = in_data >> (idx * DATA_WIDTH);
        win_data = data_sh[DATA_WIDTH-1:0];
      end
    end
  end

  // Grant only when the slot can take a beat; nothing is granted under reset.
  always_comb begin
    slot_free = ~out_vld_q | out_rdy;
    grant     = slot_free & found & ~rst;
    in_rdy    = '0;
    for (int i = 0; i < N_INPUT; i++) begin
      in_rdy[i] = grant && (win_id == ID_W'(i));
    end
  end

  // Load on grant, empty on drain, otherwise hold the current beat.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    last_id_d  = last_id_q;
    if (grant) begin
      out_vld_d  = 1'b1;
      out_data_d = win_data;
      out_id_d   = win_id;
      last_id_d  = win_id;
    end else if (out_rdy) begin
      out_vld_d  = 1'b0;
    end
  end

  // Output slot and rotation pointer; reset points the rotation at the top index.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= '0;
      last_id_q  <= ID_W'(N_INPUT - 1);
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      last_id_q  <= last_id_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_id   = out_id_q;

endmodule
